// File: rtl/cmp_stream_pkg.sv
// Shared encodings for the streaming comparator: one-hot {g,e,l} codes,
// compare-mode constants and the window tracker states.
package cmp_pkg;

  localparam logic [2:0] GEL_GT = 3'b100;
  localparam logic [2:0] GEL_EQ = 3'b010;
  localparam logic [2:0] GEL_LT = 3'b001;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } trk_state_t;

endpackage

// File: rtl/cmp_stream_if.sv
// Sample/result handshake bundle between producer, comparator and consumer.
interface cmp_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             g;
  logic             e;
  logic             l;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, g, e, l
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, g, e, l
  );
endinterface

// File: rtl/cmp_stream_core.sv
// Combinational WIDTH-bit compare in two's-complement or unsigned mode,
// returning one-hot {g,e,l}.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic [2:0]       gel
);

  // Differing signs in signed mode decide directly; otherwise a magnitude
  // compare is correct for both modes.
  always_comb begin
    gel = GEL_EQ;
    if (signed_mode == MODE_SIGNED && a[WIDTH-1] != b[WIDTH-1]) begin
      gel = a[WIDTH-1] ? GEL_LT : GEL_GT;
    end else if (a > b) begin
      gel = GEL_GT;
    end else if (a < b) begin
      gel = GEL_LT;
    end
  end

endmodule

// File: rtl/cmp_stream.sv
// Two-stage valid/ready comparator pipeline with a windowed min/max tracker
// on operand a of every delivered result.
module cmp_stream
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst,
  cmp_stream_if.slave      bus,
  input  logic             clear,
  output logic             win_done,
  output logic [WIDTH-1:0] win_max,
  output logic [WIDTH-1:0] win_min,
  output logic             win_mixed
);

  localparam int unsigned CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  logic             advance;
  logic             hs;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_mode;
  logic [2:0]       s1_gel;

  logic             o_valid;
  logic [2:0]       o_gel;
  logic [WIDTH-1:0] o_a;
  logic             o_mode;

  trk_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] cur_max;
  logic [WIDTH-1:0] cur_min;
  logic             win_mode;
  logic             mixed;
  logic [2:0]       gel_hi;
  logic [2:0]       gel_lo;
  logic             same_mode;
  logic [WIDTH-1:0] nxt_max;
  logic [WIDTH-1:0] nxt_min;
  logic             nxt_mixed;

  assign advance       = !o_valid || bus.out_ready;
  assign bus.in_ready  = !rst && advance;
  assign bus.out_valid = o_valid;
  assign bus.g         = o_gel[2];
  assign bus.e         = o_gel[1];
  assign bus.l         = o_gel[0];
  assign hs            = o_valid && bus.out_ready;

  // Stage 1: capture the operand pair and its mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_a     <= bus.a;
      s1_b     <= bus.b;
      s1_mode  <= bus.signed_mode;
    end
  end

  cmp_core #(.WIDTH(WIDTH)) u_stage2 (
    .a           (s1_a),
    .b           (s1_b),
    .signed_mode (s1_mode),
    .gel         (s1_gel)
  );

  // Stage 2: register the compare result; flags are all-zero when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_gel   <= '0;
    end else if (advance) begin
      o_valid <= s1_valid;
      o_gel   <= s1_valid ? s1_gel : 3'b000;
      o_a     <= s1_a;
      o_mode  <= s1_mode;
    end
  end

  cmp_core #(.WIDTH(WIDTH)) u_trk_max (
    .a           (o_a),
    .b           (cur_max),
    .signed_mode (win_mode),
    .gel         (gel_hi)
  );

  cmp_core #(.WIDTH(WIDTH)) u_trk_min (
    .a           (o_a),
    .b           (cur_min),
    .signed_mode (win_mode),
    .gel         (gel_lo)
  );

  // Candidate window extrema/mixed flag if the delivered sample is folded in.
  always_comb begin
    same_mode = (o_mode == win_mode);
    nxt_max   = (same_mode && gel_hi == GEL_GT) ? o_a : cur_max;
    nxt_min   = (same_mode && gel_lo == GEL_LT) ? o_a : cur_min;
    nxt_mixed = mixed || !same_mode;
  end

  // Window tracker: accumulate on each delivered result, publish at WINDOW.
  always_ff @(posedge clk) begin
    win_done <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      cur_max   <= '0;
      cur_min   <= '0;
      win_mode  <= MODE_UNSIGNED;
      mixed     <= 1'b0;
      win_max   <= '0;
      win_min   <= '0;
      win_mixed <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      count <= '0;
    end else if (hs) begin
      unique case (state)
        IDLE: begin
          win_mode <= o_mode;
          cur_max  <= o_a;
          cur_min  <= o_a;
          mixed    <= 1'b0;
          if (WINDOW == 1) begin
            win_done  <= 1'b1;
            win_max   <= o_a;
            win_min   <= o_a;
            win_mixed <= 1'b0;
            count     <= '0;
          end else begin
            count <= CW'(1);
            state <= ACCUM;
          end
        end
        ACCUM: begin
          cur_max <= nxt_max;
          cur_min <= nxt_min;
          mixed   <= nxt_mixed;
          if (count == LAST) begin
            win_done  <= 1'b1;
            win_max   <= nxt_max;
            win_min   <= nxt_min;
            win_mixed <= nxt_mixed;
            count     <= '0;
            state     <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_stream.sv
// Directed plus random bench for cmp_stream against a behavioural model of
// the two-slot pipeline and the window statistics.
module tb_cmp_stream;

  localparam int unsigned W   = 8;
  localparam int unsigned WIN = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         win_done;
  logic [W-1:0] win_max;
  logic [W-1:0] win_min;
  logic         win_mixed;

  always #5 clk = ~clk;

  cmp_stream_if #(.WIDTH(W)) bus ();

  cmp_stream #(.WIDTH(W), .WINDOW(WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clear     (clear),
    .win_done  (win_done),
    .win_max   (win_max),
    .win_min   (win_min),
    .win_mixed (win_mixed)
  );

  int errs   = 0;
  int checks = 0;

  // model: two pipeline slots, current window contents, published stats
  logic         p1v = 1'b0, p2v = 1'b0;
  logic [2:0]   p1g = 3'b000, p2g = 3'b000;
  logic [W-1:0] p1a = '0, p2a = '0;
  logic         p1m = 1'b0, p2m = 1'b0;
  logic [W-1:0] wq_a[$];
  logic         wq_m[$];
  logic         m_wd = 1'b0;
  logic [W-1:0] m_max = '0, m_min = '0;
  logic         m_mixed = 1'b0;
  logic         last_acc = 1'b0;

  function automatic int val(input logic [W-1:0] x, input logic m);
    return m ? int'($signed(x)) : int'(x);
  endfunction

  function automatic logic [2:0] ref_gel(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    int vx, vy;
    vx = val(x, m);
    vy = val(y, m);
    if (vx > vy) return 3'b100;
    if (vx == vy) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic finish_window();
    logic         mode0, mx;
    logic [W-1:0] hi, lo;
    mode0 = wq_m[0];
    hi = wq_a[0];
    lo = wq_a[0];
    mx = 1'b0;
    foreach (wq_a[i]) begin
      if (wq_m[i] != mode0) mx = 1'b1;
      else begin
        if (val(wq_a[i], mode0) > val(hi, mode0)) hi = wq_a[i];
        if (val(wq_a[i], mode0) < val(lo, mode0)) lo = wq_a[i];
      end
    end
    m_max = hi;
    m_min = lo;
    m_mixed = mx;
    m_wd = 1'b1;
    wq_a.delete();
    wq_m.delete();
  endtask

  // One clock: check current outputs, let the edge pass, advance the model.
  task automatic cycle();
    logic         adv, iv, ordy, cl, r, im;
    logic [W-1:0] ia, ib;
    #1;
    r = rst; iv = bus.in_valid; ordy = bus.out_ready; cl = clear;
    ia = bus.a; ib = bus.b; im = bus.signed_mode;
    adv = !p2v || ordy;
    chk("in_ready", bus.in_ready, !r && adv);
    chk("out_valid", bus.out_valid, p2v);
    chk("gel", {bus.g, bus.e, bus.l}, p2v ? p2g : 3'b000);
    chk("win_done", win_done, m_wd);
    chk("win_max", win_max, m_max);
    chk("win_min", win_min, m_min);
    chk("win_mixed", win_mixed, m_mixed);
    @(posedge clk);
    m_wd = 1'b0;
    last_acc = !r && adv && iv;
    if (r) begin
      p1v = 1'b0; p2v = 1'b0;
      wq_a.delete(); wq_m.delete();
      m_max = '0; m_min = '0; m_mixed = 1'b0;
    end else begin
      if (cl) begin
        wq_a.delete(); wq_m.delete();
      end else if (p2v && ordy) begin
        wq_a.push_back(p2a);
        wq_m.push_back(p2m);
        if (wq_a.size() == WIN) finish_window();
      end
      if (adv) begin
        p2v = p1v; p2g = p1g; p2a = p1a; p2m = p1m;
        p1v = iv; p1g = ref_gel(ia, ib, im); p1a = ia; p1m = im;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    bus.in_valid = 1'b1; bus.a = x; bus.b = y; bus.signed_mode = m;
    for (int k = 0; k < 64; k++) begin
      cycle();
      if (last_acc) break;
    end
    chk("accept_timeout", last_acc, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [2:0] exp);
    #1;
    chk(tag, {bus.g, bus.e, bus.l}, exp);
  endtask

  initial begin
    int idx;
    logic [W-1:0] bp_a[6];
    rst = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.signed_mode = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(1);

    // signed vs unsigned on the same pair
    send(8'h00, 8'h80, 1'b1);
    cycle();
    peek("signed_00_80", 3'b100);
    send(8'h00, 8'h80, 1'b0);
    cycle();
    peek("unsigned_00_80", 3'b001);
    idle(2);

    // back-to-back with latency 2
    send(8'h7F, 8'h80, 1'b1);
    send(8'h05, 8'h05, 1'b1);
    peek("b2b_g", 3'b100);
    send(8'h03, 8'h09, 1'b1);
    peek("b2b_e", 3'b010);
    cycle();
    peek("b2b_l", 3'b001);
    idle(3);

    // backpressure: 5 stalled cycles mid-stream, 6 samples
    for (int i = 0; i < 6; i++) bp_a[i] = W'($urandom);
    idx = 0;
    for (int t = 0; t < 40 && (idx < 6 || p2v || p1v); t++) begin
      bus.out_ready = !(t >= 2 && t < 7);
      bus.in_valid = (idx < 6);
      if (idx < 6) begin
        bus.a = bp_a[idx]; bus.b = W'($urandom); bus.signed_mode = 1'($urandom);
      end
      cycle();
      if (last_acc) idx++;
    end
    chk("bp_all_accepted", idx, 6);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    idle(2);

    // full signed window
    clear = 1'b1; cycle(); clear = 1'b0;
    send(8'h10, W'($urandom), 1'b1);
    send(8'hF0, W'($urandom), 1'b1);
    send(8'h7F, W'($urandom), 1'b1);
    send(8'h00, W'($urandom), 1'b1);
    idle(4);
    chk("win1_max", win_max, 8'h7F);
    chk("win1_min", win_min, 8'hF0);
    chk("win1_mixed", win_mixed, 1'b0);

    // mixed-mode window
    clear = 1'b1; cycle(); clear = 1'b0;
    send(8'h20, 8'h00, 1'b1);
    send(8'hFF, 8'h00, 1'b0);
    send(8'h01, 8'h00, 1'b1);
    send(8'h30, 8'h00, 1'b1);
    idle(4);
    chk("win2_max", win_max, 8'h30);
    chk("win2_min", win_min, 8'h01);
    chk("win2_mixed", win_mixed, 1'b1);

    // clear coincides with the completing handshake
    clear = 1'b1; cycle(); clear = 1'b0;
    send(8'h40, 8'h00, 1'b1);
    send(8'h41, 8'h00, 1'b1);
    send(8'h42, 8'h00, 1'b1);
    idle(3);
    send(8'h43, 8'h00, 1'b1);
    cycle();
    clear = 1'b1; cycle(); clear = 1'b0;
    idle(3);
    chk("clr_max_kept", win_max, 8'h30);
    send(8'h05, 8'h00, 1'b1);
    send(8'h80, 8'h00, 1'b1);
    send(8'h7E, 8'h00, 1'b1);
    send(8'h11, 8'h00, 1'b1);
    idle(4);
    chk("win3_max", win_max, 8'h7E);
    chk("win3_min", win_min, 8'h80);
    chk("win3_mixed", win_mixed, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a = W'($urandom);
      bus.b = ($urandom_range(0, 3) == 0) ? bus.a : W'($urandom);
      bus.signed_mode = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 31) == 0);
      cycle();
    end
    clear = 1'b0;

    // reset with samples in flight
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    idle(2);
    rst = 1'b1; bus.in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_midstream_out_valid", bus.out_valid, 1'b0);
    idle(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cmp_stream.md
Name: cmp_stream

Overview:
- Streaming, parametrised successor to the combinational 4-bit signed comparator.
- Compares WIDTH-bit operand pairs in either two's-complement or unsigned mode, chosen per sample.
- Passes each pair through a 2-stage valid/ready pipeline and emits registered one-hot g/e/l flags.
- Tracks the running min/max of operand a over a window of WINDOW accepted results and reports them at each window end. Sits between a sample producer and a statistics/threshold consumer.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2 to 32).
- WINDOW, 16, accepted results per min/max window (legal range 1 to 65535).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a pair on a/b/signed_mode.
- in_ready  output  1  block accepts a pair this cycle.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- signed_mode  input  1  1 = two's complement, 0 = unsigned; sampled with the pair.
- out_valid  output  1  g/e/l hold a valid result.
- out_ready  input  1  consumer takes the result.
- g  output  1  a > b.
- e  output  1  a == b.
- l  output  1  a < b.
- clear  input  1  synchronous window abort; the pipeline is unaffected.
- win_done  output  1  one-cycle pulse: window complete, win_max/win_min updated.
- win_max  output  WIDTH  maximum of a over the last completed window.
- win_min  output  WIDTH  minimum of a over the last completed window.
- win_mixed  output  1  last completed window contained samples whose mode differed from the first sample's mode.

Behaviour:
- Reset (rst=1 at a clock edge): clears out_valid, g, e, l, win_done, win_max, win_min, win_mixed, both stage valids, the window counter and the tracker state. in_ready is 0 during reset and comb-derived after it.
- Pipeline stall rule: advance = !out_valid || out_ready, and in_ready = advance.
  - Each stage moves only on advance.
  - With no stall, the result appears on g/e/l exactly 2 cycles after acceptance.
  - Stalled outputs stay stable while out_valid=1 and out_ready=0.
  - No sample is dropped or duplicated.
- Stage 1: registers a, b, mode and the sign bits sa = a[WIDTH-1] and sb = b[WIDTH-1].
- Stage 2 compare rules:
  - Signed mode, sa != sb: the negative operand is smaller.
  - Signed mode, sa == sb: WIDTH-bit magnitude compare.
  - Unsigned mode: plain WIDTH-bit compare.
- Exactly one of g/e/l is 1 while out_valid=1. All three are 0 when out_valid=0.
- Window tracker, with states IDLE (count=0) and ACCUM (0<count<WINDOW). Events occur only on an output handshake (out_valid && out_ready).
  - IDLE + handshake: win_mode is latched from the sample, cur_max and cur_min are set to a, count becomes 1, mixed is cleared. Go to ACCUM; if WINDOW=1, complete immediately instead.
  - ACCUM + handshake, same mode: cur_max and cur_min are updated under win_mode ordering, count increments.
  - ACCUM + handshake, mode != win_mode: count increments, min/max are not updated, mixed is set.
  - Completion: the handshake that makes count reach WINDOW triggers it. Next cycle win_done=1 and win_max/win_min/win_mixed are loaded, including the completing sample's contribution. The tracker then returns to IDLE.
  - win_max/win_min/win_mixed hold their values between completions.
- clear=1: the tracker goes to IDLE and count goes to 0; win_* outputs are untouched.
  - clear in the same cycle as the completing handshake: clear wins and win_done is not asserted.
  - clear with a non-completing handshake: the sample is discarded from the window.
- Mid-operation reset: everything in flight is lost and no result or win_done is emitted afterward.
- Counter width is $clog2(WINDOW+1).

Decomposition:
- Shared package/header `cmp_pkg`:
  - GEL_GT/GEL_EQ/GEL_LT 3-bit encodings {g,e,l}.
  - Mode constants MODE_UNSIGNED=0 and MODE_SIGNED=1.
  - Tracker state encodings IDLE/ACCUM.
- Sub-module `cmp_core`: combinational WIDTH-parametrised signed/unsigned compare returning {g,e,l}. It is instantiated in stage 2 and twice in the tracker (max and min update).

Test Plan:
- WIDTH=4, signed, a=0000, b=1000 -> 2 cycles later g=1,e=0,l=0. Unsigned, same pair -> l=1.
- WIDTH=8, back-to-back (0x7F,0x80 signed) then (0x05,0x05) then (0x03,0x09) with out_ready=1 -> g, e, l on consecutive cycles, out_valid continuously 1, latency 2.
- Backpressure: out_ready=0 for 5 cycles mid-stream -> in_ready=0 after the pipeline fills, g/e/l stable, all 6 results delivered in order once out_ready=1.
- WINDOW=4, signed, a = 0x10, 0xF0, 0x7F, 0x00 -> one win_done pulse, win_max=0x7F, win_min=0xF0, win_mixed=0.
- WINDOW=4, first sample signed then one unsigned a=0xFF -> 0xFF excluded from min/max, win_mixed=1, win_done after the 4th handshake.
- clear asserted together with the 4th handshake -> no win_done and previous win_* unchanged. The next 4 samples complete a fresh window. rst mid-stream -> out_valid=0 the next cycle.
